regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with an in-file busy scoreboard. It generalises the single-write, two-read architectural register file to NRD read ports and NWR write ports, with configurable width and depth. It adds optional same-cycle write-to-read bypass and per-register busy tracking, so decode can detect pending producers. It sits between decode (reads, busy allocation) and writeback (writes, busy release).

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, number of registers; power of two, ≥2
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored state only
- ZERO_REG, 1, 1 = register 0 hard-wired to zero, never written, never busy
- AW, derived = $clog2(NREGS), address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- ra[NRD]  in  AW  read addresses
- rd[NRD]  out  XLEN  read data
- rbusy[NRD]  out  1  busy bit of ra[i]
- wvalid[NWR]  in  1  write enables
- wa[NWR]  in  AW  write addresses
- wd[NWR]  in  XLEN  write data
- alloc_valid  in  1  mark register alloc_addr busy (new producer issued)
- alloc_addr  in  AW  register to mark busy
- flush  in  1  clear every busy bit (pipeline flush)

## Operation
- State: regs[NREGS] of XLEN bits, busy[NREGS] of 1 bit.
- Write: on a rising edge, each port with wvalid[j]=1 writes wd[j] to regs[wa[j]].
  - Same-address conflict between ports: the highest port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Busy update on a rising edge, highest priority first:
  - flush=1: all busy bits are cleared; alloc_valid is ignored that cycle.
  - Otherwise, alloc_valid=1 sets busy[alloc_addr].
  - Otherwise, any valid write to a register clears its busy bit.
  - Alloc and write to the same register in one cycle: data is written and busy ends at 1, because the new producer supersedes the old one.
  - ZERO_REG=1: busy[0] is never set.
- Read (combinational) from port i:
  - ZERO_REG=1 and ra[i]=0: rd[i]=0 and rbusy[i]=0.
  - BYPASS=1 and some wvalid[j] with wa[j]=ra[i]: rd[i]=wd of the highest matching j, and rbusy[i]=0 unless busy[ra[i]] is being kept set by a same-cycle alloc. In that case rbusy follows the stored busy bit.
  - Otherwise: rd[i]=regs[ra[i]] and rbusy[i]=busy[ra[i]].
- Reads never have side effects, and read ports are fully independent of one another.

## Timing
- Reset asserted (reset=0): all regs cleared to 0 and all busy bits cleared to 0, asynchronously.
  - All outputs therefore read 0 (rd=0, rbusy=0) while reset is low.
  - Deassertion is sampled synchronously by the surrounding reset synchroniser; the first write can occur on the first rising edge after reset=1.
- Write-to-read latency: 0 cycles with BYPASS=1 (same cycle), 1 cycle with BYPASS=0 (visible after the edge).
- Alloc-to-rbusy latency: 1 cycle, since there is no combinational alloc bypass.
- Reset mid-operation: in-flight writes and allocs in that cycle are lost, and state is zero.
- No handshake and no stalls: every write and alloc is accepted every cycle.

## Test plan
- Reset: load x5=0x1234, then pulse reset=0 between edges. Required: rd for ra=5 reads 0 immediately, and rbusy=0 for every address.
- Port conflict: wvalid[0]=wvalid[1]=1, wa=7/7, wd=0xAAAA/0xBBBB. Required: next cycle rd(7)=0xBBBB; with BYPASS=1, the same cycle also reads 0xBBBB.
- Zero register: ZERO_REG=1, write 0xFFFF to x0 and alloc x0. Required: rd(0)=0 and rbusy(0)=0 forever after.
- Scoreboard: alloc x3 at cycle 0. Required: rbusy(3)=1 from cycle 1. Write x3=0x42 at cycle 2. Required: rbusy(3)=0 and rd(3)=0x42 at cycle 3. Alloc plus write x3 in the same cycle leaves rbusy(3)=1.
- Flush: alloc x1, x2 and x9 on consecutive cycles, then flush=1 together with alloc x4. Required: next cycle rbusy=0 for x1, x2, x4 and x9.
- Parameter sweep: repeat the above at XLEN=32, NREGS=64, NRD=4, NWR=3 and BYPASS=0. Required: reads lag writes by exactly one cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// Decode reads operands and allocates producers; writeback writes results and releases busy bits.
module regfile_mp #(
  parameter  int XLEN     = 64,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra          [NRD],
  output logic [XLEN-1:0] rd          [NRD],
  output logic            rbusy       [NRD],
  input  logic            wvalid      [NWR],
  input  logic [AW-1:0]   wa          [NWR],
  input  logic [XLEN-1:0] wd          [NWR],
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Ports are applied in ascending order so the highest index wins a conflict.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wvalid[j] && !(ZERO_REG != 0 && wa[j] == '0)) begin
        regs_d[wa[j]] = wd[j];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wvalid[j]) begin
          busy_d[wa[j]] = 1'b0;
        end
      end
      // A new producer supersedes the write that retires the old one.
      if (alloc_valid) begin
        busy_d[alloc_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin : readPorts
    logic hit;
    for (int i = 0; i < NRD; i++) begin
      hit      = 1'b0;
      rd[i]    = regs_q[ra[i]];
      rbusy[i] = busy_q[ra[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wvalid[j] && wa[j] == ra[i]) begin
            rd[i] = wd[j];
            hit   = 1'b1;
          end
        end
      end
      // A forwarded write retires the producer unless an alloc keeps the register busy.
      if (hit) begin
        rbusy[i] = (alloc_valid && !flush && alloc_addr == ra[i]) ? busy_q[ra[i]] : 1'b0;
      end
      if (!reset || (ZERO_REG != 0 && ra[i] == '0)) begin
        rd[i]    = '0;
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule
